// File: rtl/pwm_led_pkg.sv
// Shared width helpers and default constants for the multi-channel PWM LED fader.
package pwm_led_pkg;

  // max(1, $clog2(x)): keeps degenerate counters at one bit
  function automatic int wbits(input int x);
    int w;
    w = $clog2(x);
    return (w < 1) ? 1 : w;
  endfunction

  // Level width must hold the value COUNT itself (full-on duty)
  function automatic int lw_of(input int count);
    return wbits(count + 1);
  endfunction

  function automatic int cw_of(input int count);
    return wbits(count);
  endfunction

  localparam int DEF_COUNT = 7;
  localparam int DEF_LW    = lw_of(DEF_COUNT);

endpackage

// File: rtl/pwm_led_if.sv
// Control/LED bundle between the register block (master) and the fader (slave).
interface pwm_led_if import pwm_led_pkg::*; #(
  parameter int CHANNELS = 3,
  parameter int LW       = DEF_LW
);
  logic                         ctrl_on;
  logic                         ctrl_fade;
  logic [CHANNELS-1:0][LW-1:0]  ctrl_level;
  logic [CHANNELS-1:0]          led;

  modport master (output ctrl_on, ctrl_fade, ctrl_level, input led);
  modport slave  (input ctrl_on, ctrl_fade, ctrl_level, output led);
endinterface

// File: rtl/pwm_led_channel.sv
// One LED channel: current duty level, +/-1 fade stepping and the registered pin drive.
module pwm_led_channel import pwm_led_pkg::*; #(
  parameter int COUNT  = 7,
  parameter int INVERT = 1,
  parameter int LW     = lw_of(COUNT),
  parameter int CW     = cw_of(COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] i_pwm_cnt,
  input  logic          i_period_end,
  input  logic          i_step,
  input  logic [LW-1:0] i_target,
  input  logic          i_ctrl_fade,
  input  logic          i_force_off,
  output logic          o_led
);
  localparam int   W   = (LW > CW) ? LW : CW;
  localparam logic INV = INVERT[0];

  logic [LW-1:0] r_level;
  logic          r_led = INV;
  logic [LW-1:0] w_next;
  logic [W-1:0]  w_lvl_x, w_cnt_x;
  logic          w_active;

  assign w_lvl_x  = W'(r_level);
  assign w_cnt_x  = W'(i_pwm_cnt);
  assign w_active = (w_lvl_x > w_cnt_x);

  // Level only moves at a period boundary, except the forced-off path
  always_comb begin
    w_next = r_level;
    if (i_force_off) begin
      w_next = '0;
    end else if (i_period_end) begin
      if (!i_ctrl_fade)
        w_next = i_target;
      else if (i_step) begin
        if (r_level < i_target)      w_next = r_level + LW'(1);
        else if (r_level > i_target) w_next = r_level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= '0;
      r_led   <= INV;
    end else begin
      r_level <= w_next;
      r_led   <= i_force_off ? INV : (w_active ^ INV);
    end
  end

  assign o_led = r_led;
endmodule

// File: rtl/pwm_led_fader.sv
// Multi-channel PWM LED driver: shared divider/PWM/fade time base, per-channel clamp and level logic.
module pwm_led_fader import pwm_led_pkg::*; #(
  parameter int CHANNELS = 3,
  parameter int DIVISOR  = 1,
  parameter int COUNT    = 7,
  parameter int INVERT   = 1,
  parameter int FADE_DIV = 4
) (
  input logic       clk,
  input logic       reset,
  pwm_led_if.slave  bus
);
  localparam int LW = lw_of(COUNT);
  localparam int CW = cw_of(COUNT);
  localparam int DW = wbits(DIVISOR);
  localparam int FW = wbits(FADE_DIV);

  logic [DW-1:0] r_div_cnt;
  logic [CW-1:0] r_pwm_cnt;
  logic [FW-1:0] r_fade_cnt;
  logic          w_tick, w_period_end, w_step, w_force_off;
  logic [CHANNELS-1:0][LW-1:0] w_target;

  assign w_tick       = (r_div_cnt == DW'(DIVISOR - 1));
  assign w_period_end = w_tick && (r_pwm_cnt == CW'(COUNT - 1));
  assign w_step       = w_period_end && (r_fade_cnt == FW'(FADE_DIV - 1));
  // Jump mode with the enable dropped bypasses the period boundary
  assign w_force_off  = !bus.ctrl_fade && !bus.ctrl_on;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_pwm_cnt  <= '0;
      r_fade_cnt <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DW'(1);
      if (w_tick)
        r_pwm_cnt <= w_period_end ? '0 : r_pwm_cnt + CW'(1);
      if (w_period_end)
        r_fade_cnt <= w_step ? '0 : r_fade_cnt + FW'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_target[g] = !bus.ctrl_on                         ? '0 :
                         (bus.ctrl_level[g] > LW'(COUNT))     ? LW'(COUNT) :
                                                                bus.ctrl_level[g];

    pwm_led_channel #(
      .COUNT  (COUNT),
      .INVERT (INVERT),
      .LW     (LW),
      .CW     (CW)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .i_pwm_cnt    (r_pwm_cnt),
      .i_period_end (w_period_end),
      .i_step       (w_step),
      .i_target     (w_target[g]),
      .i_ctrl_fade  (bus.ctrl_fade),
      .i_force_off  (w_force_off),
      .o_led        (bus.led[g])
    );
  end
endmodule

// File: tb/tb_pwm_led_fader.sv
// Bench: two fader configs (active-high divided, active-low undivided) against a time-based reference model.
module tb_pwm_led_fader;
  localparam int CH = 3;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                  on = 1'b0, fade = 1'b0;
  logic [CH-1:0][LW-1:0] lvl = '0;

  pwm_led_if #(.CHANNELS(CH), .LW(LW)) ifa ();
  pwm_led_if #(.CHANNELS(CH), .LW(LW)) ifb ();
  assign ifa.ctrl_on = on;  assign ifa.ctrl_fade = fade;  assign ifa.ctrl_level = lvl;
  assign ifb.ctrl_on = on;  assign ifb.ctrl_fade = fade;  assign ifb.ctrl_level = lvl;

  pwm_led_fader #(.CHANNELS(CH), .DIVISOR(2), .COUNT(4), .INVERT(0), .FADE_DIV(2))
    dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  pwm_led_fader #(.CHANNELS(CH), .DIVISOR(1), .COUNT(4), .INVERT(1), .FADE_DIV(1))
    dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  int total = 0, bad = 0;

  // Reference model: everything derived from the clock count since reset release
  int md[2] = '{2, 1};
  int mc[2] = '{4, 4};
  int mi[2] = '{0, 1};
  int mf[2] = '{2, 1};
  int mt[2];
  int mlvl[2][CH];
  logic [CH-1:0] mled[2];
  int hi[2][CH];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      mt[d] = 0;
      mled[d] = (mi[d] != 0) ? '1 : '0;
      for (int c = 0; c < CH; c++) mlvl[d][c] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int d = 0; d < 2; d++) begin
      int per, pc, tg;
      bit pe, st, fo, act;
      per = md[d] * mc[d];
      pc  = (mt[d] / md[d]) % mc[d];
      pe  = (mt[d] % per) == per - 1;
      st  = pe && (((mt[d] / per) % mf[d]) == mf[d] - 1);
      fo  = !fade && !on;
      for (int c = 0; c < CH; c++) begin
        tg  = !on ? 0 : ((int'(lvl[c]) > mc[d]) ? mc[d] : int'(lvl[c]));
        act = fo ? 1'b0 : (mlvl[d][c] > pc);
        mled[d][c] = act ^ (mi[d] != 0);
        if (fo) mlvl[d][c] = 0;
        else if (pe) begin
          if (!fade) mlvl[d][c] = tg;
          else if (st) begin
            if (mlvl[d][c] < tg)      mlvl[d][c]++;
            else if (mlvl[d][c] > tg) mlvl[d][c]--;
          end
        end
      end
      mt[d]++;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ledA", int'(ifa.led), int'(mled[0]));
    check("ledB", int'(ifb.led), int'(mled[1]));
    for (int c = 0; c < CH; c++) begin
      if (ifa.led[c] == 1'b1) hi[0][c]++;
      if (ifb.led[c] == 1'b0) hi[1][c]++;
    end
  endtask

  task automatic window(input int n);
    for (int d = 0; d < 2; d++) for (int c = 0; c < CH; c++) hi[d][c] = 0;
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("rstA", int'(ifa.led), 0);
    check("rstB", int'(ifb.led), 7);
    @(negedge clk);
    @(negedge clk);
    check("rstA_hold", int'(ifa.led), 0);
    reset = 1'b0;
  endtask

  typedef struct { bit on; int l0, l1, l2; int e0, e1, e2; } vec_t;
  vec_t vt[4];
  int up[7] = '{0, 0, 2, 2, 4, 4, 6};
  int dn[7] = '{6, 6, 4, 4, 2, 2, 0};

  initial begin
    // Active clocks per 8-clock window; both configs give 2*min(level,4)
    vt[0] = '{1'b1, 0, 2, 4, 0, 4, 8};
    vt[1] = '{1'b1, 1, 3, 7, 2, 6, 8};
    vt[2] = '{1'b0, 4, 4, 4, 0, 0, 0};
    vt[3] = '{1'b1, 5, 0, 2, 8, 0, 4};

    model_reset();
    do_reset();

    on = 1'b1; fade = 1'b0;
    lvl[0] = 3'd0; lvl[1] = 3'd2; lvl[2] = 3'd4;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("pre_period_end", int'(ifa.led), 0);
    end

    for (int i = 0; i < 4; i++) begin
      on = vt[i].on;
      lvl[0] = 3'(vt[i].l0); lvl[1] = 3'(vt[i].l1); lvl[2] = 3'(vt[i].l2);
      while (mt[0] % 8 != 0) cyc();
      repeat (8) cyc();
      window(8);
      check("vecA0", hi[0][0], vt[i].e0);
      check("vecA1", hi[0][1], vt[i].e1);
      check("vecA2", hi[0][2], vt[i].e2);
      check("vecB0", hi[1][0], vt[i].e0);
      check("vecB1", hi[1][1], vt[i].e1);
      check("vecB2", hi[1][2], vt[i].e2);
    end

    // Level change mid-period must not disturb the running period
    do_reset();
    on = 1'b1; fade = 1'b0; lvl = '0; lvl[0] = 3'd1;
    repeat (16) cyc();
    window(4);
    lvl[0] = 3'd3;
    repeat (4) cyc();
    check("glitch_cur", hi[0][0], 2);
    window(8);
    check("glitch_next", hi[0][0], 6);

    // Immediate off in jump mode
    lvl[0] = 3'd4; lvl[1] = 3'd4; lvl[2] = 3'd4;
    repeat (19) cyc();
    check("full_on", int'(ifa.led), 7);
    on = 1'b0;
    cyc();
    check("off_A", int'(ifa.led), 0);
    check("off_B", int'(ifb.led), 7);
    repeat (2) cyc();
    check("off_A_hold", int'(ifa.led), 0);

    // Fade up then down on channel 0
    do_reset();
    fade = 1'b1; on = 1'b1; lvl = '0; lvl[0] = 3'd3;
    for (int p = 0; p < 7; p++) begin
      window(8);
      check("fade_up", hi[0][0], up[p]);
    end
    window(8);
    on = 1'b0;
    for (int p = 0; p < 7; p++) begin
      window(8);
      check("fade_dn", hi[0][0], dn[p]);
    end

    // Async reset mid-fade at level 2, then fade restarts from 0
    do_reset();
    on = 1'b1;
    repeat (36) cyc();
    check("pre_reset_hi", int'(ifa.led[0]), 1);
    do_reset();
    for (int p = 0; p < 3; p++) begin
      window(8);
      check("fade_restart", hi[0][0], up[p]);
    end

    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      on   = ($urandom_range(0, 3) != 0);
      fade = 1'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++) lvl[c] = 3'($urandom_range(0, 7));
      repeat ($urandom_range(1, 40)) cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_led_fader.md
# pwm_led_fader

Multi-channel PWM LED driver with per-channel intensity, clamping, glitch-free level updates and optional linear fading. It is the general successor of the fixed three-channel RGB driver: it sits between a register/control block and the LED pins, with one shared PWM time base and N independent channels.

## Interface
- `CHANNELS`, 3: number of LED channels (≥1).
- `DIVISOR`, 1: clocks per PWM counter step (≥1).
- `COUNT`, 7: PWM counter states, counting 0..COUNT-1 (≥2). Fpwm = Fclk/(DIVISOR*COUNT).
- `INVERT`, 1: 0 = active-high outputs, 1 = active-low outputs.
- `FADE_DIV`, 4: PWM periods per fade step (≥1).
- `reset`: input, 1 bit. Asynchronous, active-high.
- `clk`: input, 1 bit. Single clock domain.
- `ctrl_on`: input, 1 bit. Global enable.
- `ctrl_fade`: input, 1 bit. 1 = levels ramp toward target; 0 = levels jump to target.
- `ctrl_level`: input, CHANNELS × LW bits. Per-channel target level. LW = $clog2(COUNT+1).
- `led`: output, CHANNELS bits. Registered LED drive.

## Operation
- **Divider.** `div_cnt` counts 0..DIVISOR-1 and wraps. `tick` = (div_cnt == DIVISOR-1). With DIVISOR=1, `tick` is constantly 1. Counter width is max(1, $clog2(DIVISOR)).
- **PWM counter.** `pwm_cnt` (width max(1, $clog2(COUNT))) increments on `tick` and wraps to 0 after COUNT-1. `period_end` = tick && pwm_cnt == COUNT-1.
- **Target.** target[i] = ctrl_on ? min(ctrl_level[i], COUNT) : 0. Clamping is an unsigned compare in LW bits.
- **Fade step counter.** `fade_cnt` counts `period_end` events 0..FADE_DIV-1. `step` = period_end && fade_cnt == FADE_DIV-1.
- **Level update.** `level[i]` is the current duty. It changes only on `period_end`, so no partial or glitched period ever occurs.
  - ctrl_fade=0: level <= target.
  - ctrl_fade=1: on `step` only, level moves ±1 toward target. It holds when equal. It never overshoots.
- **Immediate off.** When ctrl_fade=0 and ctrl_on=0:
  - level is cleared to 0 on the next edge, regardless of `period_end`;
  - outputs go inactive on that same edge.
  - When ctrl_fade=1, ctrl_on=0 instead fades all channels down to 0.
- **Output.** led[i] <= (level[i] > pwm_cnt) XOR INVERT.
  - level 0 gives output always inactive.
  - level COUNT gives output always active.
- **Mode change mid-period.** Toggling ctrl_fade takes effect at the next `period_end`. ctrl_level changes are sampled only at `period_end`.

## Timing
- Reset values:
  - div_cnt, pwm_cnt, fade_cnt, all level = 0;
  - led = {CHANNELS{INVERT[0]}}, i.e. all inactive.
  - Outputs also carry this value as their initial value.
- Reset asserted mid-period or mid-fade: all state returns to reset values immediately, asynchronously. After release, the first period starts with pwm_cnt = 0.
- Output latency: led reflects (level, pwm_cnt) from the previous cycle, i.e. one register stage.
- New target to duty:
  - fade off: at most DIVISOR*COUNT clocks to the next `period_end`, plus 1 cycle.
  - fade on: |target-level| × FADE_DIV periods.
- Simultaneous `period_end` and reset: reset wins.
- Simultaneous `period_end` and ctrl_on fall with fade off: level = 0.

## Structure
- Package `pwm_led_pkg` holds:
  - a width helper function, max(1, $clog2(x));
  - localparam-style constants for LW and pwm counter width, derived from COUNT.
- Top `pwm_led_fader` holds the divider, pwm_cnt, fade_cnt and the target clamp.
- Sub-module `pwm_led_channel` is instantiated CHANNELS times via generate. It holds the level register, the up/down step logic and the output register, and takes pwm_cnt, period_end, step, target, ctrl_fade, force_off and INVERT.
- Expected size: 150–250 lines total.

## Test plan
1. **Steady duty.** CHANNELS=3, DIVISOR=2, COUNT=4, INVERT=0, fade off, levels {0,2,4}, ctrl_on=1 → per 8-clock period, led0 high 0 clocks, led1 high 4 contiguous clocks, led2 high 8 clocks. Outputs are all 0 before the first `period_end` and during reset.
2. **Clamp and invert.** COUNT=4, INVERT=1, level 7 → led constantly 0 (active-low, full on). Level 0 → constantly 1.
3. **Fade up and down.** FADE_DIV=2, fade on, target 0→3 → level steps to 1, 2, 3 at every 2nd `period_end` and reaches 3 after 6 periods. Then ctrl_on=0 → level steps down 2, 1, 0 at the same rate.
4. **Glitch-free update.** Change ctrl_level from 1 to 3 at pwm_cnt=2 → the current period completes with duty 1; the next period shows duty 3.
5. **Immediate off.** Fade off, level 4, drop ctrl_on mid-period → led inactive on the following edge, level reads 0. With fade on → a gradual ramp instead.
6. **Async reset.** Assert reset mid-fade at level 2 → led returns to INVERT immediately and all counters read 0. After release, fading restarts from level 0.
